// File: rtl/aes_key_expander_if.sv
// Load/read bus between the AES-128 key schedule and the cipher core.
// The master side requests key loads and reads round keys; the slave is the expander.
interface aes_key_expander_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_ready;
  logic         key_valid;
  logic         expand_done;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;

  modport master (
    output key_load, key_in, rk_addr,
    input  key_ready, key_valid, expand_done, rk_out
  );

  modport slave (
    input  key_load, key_in, rk_addr,
    output key_ready, key_valid, expand_done, rk_out
  );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: captures a cipher key and derives one round key per clock
// into a local store that the round datapath reads combinationally by index.
module aes_key_expander #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  aes_key_expander_if.slave key_bus
);

  localparam int unsigned AW = $clog2(NUM_ROUNDS + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // SubWord applied to RotWord(w): bytes rotated left by one before substitution
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] o3;
    t  = sub_rot_word(k[31:0]) ^ {rcon(r), 24'h0};
    o0 = k[127:96] ^ t;
    o1 = o0 ^ k[95:64];
    o2 = o1 ^ k[63:32];
    o3 = o2 ^ k[31:0];
    return {o0, o1, o2, o3};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         expand_done_q, expand_done_d;
  logic [127:0] rk_q [NUM_ROUNDS+1];
  logic [127:0] rk_d [NUM_ROUNDS+1];
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] rd_data;

  always_comb begin
    prev_key = '0;
    for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
      if (cnt_q == 4'(i)) prev_key = rk_q[AW'(i - 1)];
    end
    next_key = key_next(prev_key, cnt_q);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rk_d          = rk_q;
    expand_done_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_bus.key_load) begin
          rk_d[0] = key_bus.key_in;
          cnt_d   = 4'd1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        for (int unsigned i = 1; i <= NUM_ROUNDS; i++) begin
          if (cnt_q == 4'(i)) rk_d[AW'(i)] = next_key;
        end
        // Counter parks at NUM_ROUNDS on the final write instead of stepping past it.
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d       = ST_DONE;
          expand_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      expand_done_q <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_q[AW'(i)] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      expand_done_q <= expand_done_d;
      rk_q          <= rk_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
      if (key_bus.rk_addr == 4'(i)) rd_data = rk_q[AW'(i)];
    end
  end

  assign key_bus.rk_out      = rd_data;
  assign key_bus.key_ready   = (state_q != ST_EXPAND);
  assign key_bus.key_valid   = (state_q == ST_DONE);
  assign key_bus.expand_done = expand_done_q;

endmodule
